// File: rtl/dtm_pkg.sv
// dtm_pkg: shared types and constants for the JTAG debug transport module.
// TAP state encoding, IR opcodes, DMI op/status encodings and DTM version.
package dtm_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1f;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2
    } dmi_op_e;

    typedef enum logic [1:0] {
        STAT_OK     = 2'd0,
        STAT_RSVD   = 2'd1,
        STAT_FAILED = 2'd2,
        STAT_BUSY   = 2'd3
    } dmi_stat_e;

    localparam logic [3:0] DTM_VERSION = 4'd1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: oversamples tck/tms/tdi on clk, tracks the IEEE 1149.1 TAP
// state, emits one-clk strobes for capture/shift/update and tck falling edge.
// Ports: clk, rst_n, tck, tms, tdi, [trst_n when DTM_TRST_EN], state, tdi_s,
// capture_dr/shift_dr/update_dr, capture_ir/shift_ir/update_ir, tck_fall.
module jtag_tap_fsm
    import dtm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
`ifdef DTM_TRST_EN
    input  logic       trst_n,
`endif
    output tap_state_e state,
    output logic       tdi_s,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       tck_fall
);

    logic [SYNC_STAGES-1:0] tck_ff;
    logic [SYNC_STAGES-1:0] tms_ff;
    logic [SYNC_STAGES-1:0] tdi_ff;
    logic                   tck_d;
    logic                   tck_s;
    logic                   tms_s;
    logic                   tck_rise;
    logic                   trst_hold;
    tap_state_e             state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_ff <= '0;
            tms_ff <= '0;
            tdi_ff <= '0;
            tck_d  <= 1'b0;
        end else begin
            tck_ff <= {tck_ff[SYNC_STAGES-2:0], tck};
            tms_ff <= {tms_ff[SYNC_STAGES-2:0], tms};
            tdi_ff <= {tdi_ff[SYNC_STAGES-2:0], tdi};
            tck_d  <= tck_ff[SYNC_STAGES-1];
        end
    end

`ifdef DTM_TRST_EN
    logic [SYNC_STAGES-1:0] trst_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trst_ff <= '0;
        end else begin
            trst_ff <= {trst_ff[SYNC_STAGES-2:0], trst_n};
        end
    end

    assign trst_hold = ~trst_ff[SYNC_STAGES-1];
`else
    assign trst_hold = 1'b0;
`endif

    assign tck_s    = tck_ff[SYNC_STAGES-1];
    assign tms_s    = tms_ff[SYNC_STAGES-1];
    assign tdi_s    = tdi_ff[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_d;
    assign tck_fall = ~tck_s & tck_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TAP_TLR;
        end else if (trst_hold) begin
            state <= TAP_TLR;
        end else if (tck_rise) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            TAP_TLR:      state_nx = tms_s ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_nx = tms_s ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_nx = tms_s ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_nx = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_nx = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_nx = tms_s ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_nx = tms_s ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_nx = tms_s ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_nx = tms_s ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_nx = tms_s ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_nx = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_nx = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_nx = tms_s ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_nx = tms_s ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_nx = tms_s ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_nx = tms_s ? TAP_SEL_DR   : TAP_RTI;
            default:      state_nx = TAP_TLR;
        endcase
    end

    // Actions belong to the state being left on this rising edge.
    always_comb begin
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        if (tck_rise && !trst_hold) begin
            capture_dr = (state == TAP_CAP_DR);
            shift_dr   = (state == TAP_SHIFT_DR);
            update_dr  = (state == TAP_UPD_DR);
            capture_ir = (state == TAP_CAP_IR);
            shift_ir   = (state == TAP_SHIFT_IR);
            update_ir  = (state == TAP_UPD_IR);
        end
    end

endmodule

// File: rtl/jtag_dtm.sv
// jtag_dtm: RISC-V 0.13 JTAG DTM; owns IR, IDCODE/DTMCS/DMI/BYPASS registers
// and the DMI valid/ready request plus response strobe. Optional DTM_TRST_EN
// adds trst_n. Ports: clk, rst_n, tck/tms/tdi/tdo, dmi_req_*, dmi_resp_*.
module jtag_dtm
    import dtm_pkg::*;
#(
    parameter int          ABITS       = 7,
    parameter logic [31:0] IDCODE      = 32'h1000_0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
`ifdef DTM_TRST_EN
    input  logic             trst_n,
`endif
    output logic             tdo,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);

    localparam int DW = ABITS + 34;

    tap_state_e       state;
    logic             tdi_s;
    logic             capture_dr;
    logic             shift_dr;
    logic             update_dr;
    logic             capture_ir;
    logic             shift_ir;
    logic             update_ir;
    logic             tck_fall;

    logic [4:0]       ir;
    logic [4:0]       ir_sr;
    logic [DW-1:0]    dr_sr;
    logic [DW-1:0]    dr_cap;
    logic [DW-1:0]    dr_nx;
    logic [1:0]       dmistat;
    logic [1:0]       cap_op;
    logic             busy;
    logic [ABITS-1:0] last_addr;
    logic [31:0]      resp_data;
    logic [31:0]      dtmcs_val;
    logic             req_ok;

    jtag_tap_fsm #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tap (
        .clk        (clk),
        .rst_n      (rst_n),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
`ifdef DTM_TRST_EN
        .trst_n     (trst_n),
`endif
        .state      (state),
        .tdi_s      (tdi_s),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tck_fall   (tck_fall)
    );

    assign dtmcs_val = {14'b0, 3'b0, 3'd1, dmistat, 6'(ABITS), DTM_VERSION};
    assign cap_op    = busy ? STAT_BUSY : dmistat;

    always_comb begin
        dr_cap = '0;
        case (ir)
            IR_IDCODE: dr_cap = DW'(IDCODE);
            IR_DTMCS:  dr_cap = DW'(dtmcs_val);
            // A response landing on the capture clk wins and reads as ok.
            IR_DMI:    dr_cap = dmi_resp_valid
                                ? {last_addr, dmi_resp_data, 2'b00}
                                : {last_addr, resp_data, cap_op};
            default:   dr_cap = '0;
        endcase
    end

    always_comb begin
        dr_nx = {{(DW-1){1'b0}}, tdi_s};
        case (ir)
            IR_DMI:   dr_nx = {tdi_s, dr_sr[DW-1:1]};
            IR_IDCODE,
            IR_DTMCS: dr_nx = {{(DW-32){1'b0}}, tdi_s, dr_sr[31:1]};
            default:  dr_nx = {{(DW-1){1'b0}}, tdi_s};
        endcase
    end

    assign req_ok = (ir == IR_DMI) && (dmistat == STAT_OK) && !busy &&
                    ((dr_sr[1:0] == DMI_READ) || (dr_sr[1:0] == DMI_WRITE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir    <= IR_IDCODE;
            ir_sr <= '0;
            dr_sr <= '0;
            tdo   <= 1'b0;
        end else begin
            if (capture_ir) begin
                ir_sr <= 5'b00001;
            end else if (shift_ir) begin
                ir_sr <= {tdi_s, ir_sr[4:1]};
            end
            if (state == TAP_TLR) begin
                ir <= IR_IDCODE;
            end else if (update_ir) begin
                ir <= ir_sr;
            end
            if (capture_dr) begin
                dr_sr <= dr_cap;
            end else if (shift_dr) begin
                dr_sr <= dr_nx;
            end
            if (state == TAP_TLR) begin
                tdo <= 1'b0;
            end else if (tck_fall) begin
                tdo <= (state == TAP_SHIFT_DR) ? dr_sr[0] :
                       (state == TAP_SHIFT_IR) ? ir_sr[0] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= '0;
            dmistat       <= STAT_OK;
            busy          <= 1'b0;
            last_addr     <= '0;
            resp_data     <= '0;
        end else begin
            if (dmi_req_valid && dmi_req_ready) begin
                dmi_req_valid <= 1'b0;
            end
            if (dmi_resp_valid) begin
                busy      <= 1'b0;
                resp_data <= dmi_resp_data;
                if (dmi_resp_op == STAT_FAILED && dmistat == STAT_OK) begin
                    dmistat <= STAT_FAILED;
                end
            end
            if (capture_dr && ir == IR_DMI && busy && !dmi_resp_valid) begin
                dmistat <= STAT_BUSY;
            end
            if (update_dr && ir == IR_DTMCS) begin
                if (dr_sr[16]) begin
                    dmistat <= STAT_OK;
                end
                if (dr_sr[17]) begin
                    busy          <= 1'b0;
                    dmi_req_valid <= 1'b0;
                end
            end
            if (update_dr && req_ok) begin
                dmi_req_valid <= 1'b1;
                dmi_req_addr  <= dr_sr[DW-1:34];
                dmi_req_data  <= dr_sr[33:2];
                dmi_req_op    <= dr_sr[1:0];
                busy          <= 1'b1;
                last_addr     <= dr_sr[DW-1:34];
            end
        end
    end

endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: drives JTAG scans and DMI handshakes against jtag_dtm;
// a behavioural model predicts scan-out words and DMI requests.
module tb_jtag_dtm;
    import dtm_pkg::*;

    localparam int          ABITS = 7;
    localparam int          DW    = ABITS + 34;
    localparam logic [31:0] IDC   = 32'h1000_0001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tck = 1'b0;
    logic             tms = 1'b1;
    logic             tdi = 1'b0;
    logic             tdo;
    logic             dmi_req_valid;
    logic             dmi_req_ready = 1'b0;
    logic [ABITS-1:0] dmi_req_addr;
    logic [31:0]      dmi_req_data;
    logic [1:0]       dmi_req_op;
    logic             dmi_resp_valid = 1'b0;
    logic [31:0]      dmi_resp_data = '0;
    logic [1:0]       dmi_resp_op = '0;
`ifdef DTM_TRST_EN
    logic             trst_n = 1'b1;
`endif

    always #10 clk = ~clk;

    jtag_dtm #(
        .ABITS(ABITS),
        .IDCODE(IDC),
        .SYNC_STAGES(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tck            (tck),
        .tms            (tms),
        .tdi            (tdi),
`ifdef DTM_TRST_EN
        .trst_n         (trst_n),
`endif
        .tdo            (tdo),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_data   (dmi_req_data),
        .dmi_req_op     (dmi_req_op),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_data  (dmi_resp_data),
        .dmi_resp_op    (dmi_resp_op)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];
    string       name_q[$];
    logic [63:0] req_q[$];

    // behavioural model of the DTM's architectural state
    logic [4:0]       m_ir = IR_IDCODE;
    logic [1:0]       m_stat = 2'd0;
    bit               m_busy = 1'b0;
    logic [ABITS-1:0] m_last_addr = '0;
    logic [31:0]      m_resp = '0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // scan-word scoreboard
    initial forever begin
        @(negedge clk);
        while (act_q.size() > 0 && exp_q.size() > 0)
            check(name_q.pop_front(), act_q.pop_front(), exp_q.pop_front());
    end

    // DMI request scoreboard: compares at every accepted handshake
    initial forever begin
        @(negedge clk);
        if (rst_n && dmi_req_valid && dmi_req_ready) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dmi_req_unexpected: got %h expected none",
                         {dmi_req_addr, dmi_req_data, dmi_req_op});
            end else begin
                check("dmi_req",
                      64'({dmi_req_addr, dmi_req_data, dmi_req_op}),
                      req_q.pop_front());
            end
        end
    end

    task automatic tclk(input logic m, input logic d, output logic o);
        tms = m;
        tdi = d;
        #100;
        o = tdo;
        tck = 1'b1;
        #100;
        tck = 1'b0;
    endtask

    task automatic tms_seq(input logic m);
        logic o;
        tclk(m, 1'b0, o);
    endtask

    task automatic shift(input int n, input logic [63:0] din,
                         output logic [63:0] dout);
        logic o;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tclk(i == n - 1, din[i], o);
            dout[i] = o;
        end
    endtask

    task automatic dr_scan(input int n, input logic [63:0] din,
                           output logic [63:0] dout);
        @(negedge clk);
        tms_seq(1'b1);
        tms_seq(1'b0);
        tms_seq(1'b0);
        shift(n, din, dout);
        tms_seq(1'b1);
        tms_seq(1'b0);
    endtask

    task automatic set_ir(input logic [4:0] v);
        logic [63:0] dout;
        if (m_ir != v) begin
            exp_q.push_back(64'h1);
            name_q.push_back("ir_capture");
            @(negedge clk);
            tms_seq(1'b1);
            tms_seq(1'b1);
            tms_seq(1'b0);
            tms_seq(1'b0);
            shift(5, 64'(v), dout);
            tms_seq(1'b1);
            tms_seq(1'b0);
            act_q.push_back(dout);
            m_ir = v;
        end
    endtask

    task automatic model_dr(input logic [63:0] din, input string nm);
        logic [63:0] e;
        logic [63:0] a;
        int          n;
        case (m_ir)
            IR_IDCODE: begin
                n = 32;
                e = 64'(IDC);
            end
            IR_DTMCS: begin
                n = 32;
                e = 64'({14'b0, 3'b0, 3'd1, m_stat, 6'(ABITS), 4'd1});
            end
            IR_DMI: begin
                n = DW;
                e = 64'({m_last_addr, m_resp, m_busy ? 2'd3 : m_stat});
                if (m_busy) m_stat = 2'd3;
            end
            default: begin
                n = 1;
                e = 64'd0;
            end
        endcase
        exp_q.push_back(e);
        name_q.push_back(nm);
        dr_scan(n, din, a);
        act_q.push_back(a);
        if (m_ir == IR_DTMCS && din[16]) m_stat = 2'd0;
        if (m_ir == IR_DTMCS && din[17]) m_busy = 1'b0;
        if (m_ir == IR_DMI && m_stat == 2'd0 && !m_busy &&
            (din[1:0] == 2'd1 || din[1:0] == 2'd2)) begin
            req_q.push_back(64'(din[DW-1:0]));
            m_busy = 1'b1;
            m_last_addr = din[DW-1:34];
        end
    endtask

    task automatic handshake(input int delay);
        for (int i = 0; i < 50 && !dmi_req_valid; i++) @(negedge clk);
        check("req_valid_wait", 64'(dmi_req_valid), 64'd1);
        repeat (delay) @(negedge clk);
        @(posedge clk);
        #2 dmi_req_ready = 1'b1;
        @(posedge clk);
        #2 dmi_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] rop);
        @(posedge clk);
        #2;
        dmi_resp_valid = 1'b1;
        dmi_resp_data = d;
        dmi_resp_op = rop;
        @(posedge clk);
        #2 dmi_resp_valid = 1'b0;
        m_busy = 1'b0;
        m_resp = d;
        if (rop == 2'd2 && m_stat == 2'd0) m_stat = 2'd2;
    endtask

    task automatic expect_idle(input string nm);
        repeat (3) @(negedge clk);
        check(nm, 64'(dmi_req_valid), 64'd0);
    endtask

    task automatic go_rti();
        @(negedge clk);
        tms_seq(1'b0);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a,
                                             input logic [31:0] d,
                                             input logic [1:0] op);
        return 64'({a, d, op});
    endfunction

    logic [6:0]  r_a;
    logic [31:0] r_d;
    logic [1:0]  r_op;
    int          nq;

    initial begin
        #30;
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_req_valid", 64'(dmi_req_valid), 64'd0);
        check("rst_req_addr", 64'(dmi_req_addr), 64'd0);
        check("rst_req_data", 64'(dmi_req_data), 64'd0);
        check("rst_req_op", 64'(dmi_req_op), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        go_rti();
        model_dr(64'h0, "idcode");

        set_ir(IR_DTMCS);
        model_dr(64'h0, "dtmcs");

        set_ir(IR_DMI);
        model_dr(dmi_word(7'h11, 32'h0, 2'd1), "dmi_cap0");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(dmi_req_valid), 64'd1);
            check("hold_addr", 64'(dmi_req_addr), 64'h11);
            check("hold_op", 64'(dmi_req_op), 64'd1);
        end
        handshake(0);
        @(negedge clk);
        check("valid_drop", 64'(dmi_req_valid), 64'd0);
        respond(32'hDEAD_BEEF, 2'd0);
        model_dr(64'h0, "nop_readback");

        model_dr(dmi_word(7'h22, 32'h1234_5678, 2'd1), "busy_issue");
        handshake(2);
        model_dr(64'h0, "busy_capture");
        set_ir(IR_DTMCS);
        model_dr(64'h0, "dtmcs_busy");
        set_ir(IR_DMI);
        model_dr(dmi_word(7'h23, 32'h5, 2'd2), "busy_blocked");
        expect_idle("busy_no_issue");
        respond(32'hCAFE_F00D, 2'd0);
        set_ir(IR_DTMCS);
        model_dr(64'h1_0000, "dtmcs_clear");
        set_ir(IR_DMI);
        model_dr(dmi_word(7'h33, 32'hA5A5_5A5A, 2'd2), "after_clear");
        handshake(1);
        respond(32'h0, 2'd0);

        set_ir(IR_BYPASS);
        model_dr(64'h1, "bypass");
        set_ir(5'h05);
        model_dr(64'h1, "bypass_other");

        set_ir(IR_DMI);
        model_dr(dmi_word(7'h44, 32'h0, 2'd1), "tlr_issue");
        @(negedge clk);
        tms_seq(1'b1);
        tms_seq(1'b0);
        tms_seq(1'b0);
        if (m_busy) m_stat = 2'd3;
        repeat (3) tms_seq(1'b0);
        repeat (5) tms_seq(1'b1);
        m_ir = IR_IDCODE;
        tms_seq(1'b0);
        @(negedge clk);
        check("tlr_req_kept", 64'(dmi_req_valid), 64'd1);
        check("tlr_req_addr", 64'(dmi_req_addr), 64'h44);
        model_dr(64'h0, "tlr_idcode");
        handshake(0);
        respond(32'h0BAD_F00D, 2'd2);
        set_ir(IR_DTMCS);
        model_dr(64'h1_0000, "tlr_clear");

        for (int it = 0; it < 14; it++) begin
            if (m_stat != 2'd0) begin
                set_ir(IR_DTMCS);
                model_dr(64'h1_0000, "rnd_clear");
            end else begin
                r_a = 7'($urandom);
                r_d = $urandom;
                r_op = 2'($urandom_range(0, 2));
                set_ir(IR_DMI);
                nq = req_q.size();
                model_dr(dmi_word(r_a, r_d, r_op), "rnd_dmi");
                if (req_q.size() > nq) begin
                    handshake($urandom_range(0, 6));
                    if ($urandom_range(0, 2) == 0)
                        model_dr(64'h0, "rnd_busy");
                    respond($urandom,
                            ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0);
                end else begin
                    expect_idle("rnd_no_issue");
                end
            end
        end

`ifdef DTM_TRST_EN
        @(negedge clk);
        tms_seq(1'b1);
        tms_seq(1'b1);
        tms_seq(1'b0);
        tms_seq(1'b0);
        tms_seq(1'b0);
        trst_n = 1'b0;
        repeat (6) @(negedge clk);
        check("trst_tdo", 64'(tdo), 64'd0);
        trst_n = 1'b1;
        repeat (4) @(negedge clk);
        m_ir = IR_IDCODE;
        go_rti();
        model_dr(64'h0, "trst_idcode");
`endif

        set_ir(IR_DMI);
        if (m_stat != 2'd0 || m_busy) begin
            set_ir(IR_DTMCS);
            model_dr(64'h3_0000, "pre_rst_clear");
            m_busy = 1'b0;
            set_ir(IR_DMI);
        end
        model_dr(dmi_word(7'h55, 32'h7777_0000, 2'd2), "rst_issue");
        for (int i = 0; i < 50 && !dmi_req_valid; i++) @(negedge clk);
        check("rst_pre_valid", 64'(dmi_req_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(dmi_req_valid), 64'd0);
        check("rst_mid_addr", 64'(dmi_req_addr), 64'd0);
        req_q.delete();
        m_ir = IR_IDCODE;
        m_stat = 2'd0;
        m_busy = 1'b0;
        m_last_addr = '0;
        m_resp = '0;
        #39;
        @(negedge clk);
        rst_n = 1'b1;
        go_rti();
        model_dr(64'h0, "post_rst_idcode");
        set_ir(IR_DMI);
        model_dr(64'h0, "post_rst_dmi");

        repeat (20) @(negedge clk);
        check("scan_queue_drained", 64'(exp_q.size()), 64'd0);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("final_idle", 64'(dmi_req_valid), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
